// File: rtl/div_clk_monitor_if.sv
// Port bundle for div_clk_monitor: the divided clock and programmed ratio in,
// ticks and measurements out.
interface div_clk_monitor_if #(
  parameter int unsigned CNT_W = 31
);
  logic             clk_in;
  logic [CNT_W-1:0] expect_period;
  logic             tick_rise;
  logic             tick_fall;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             period_valid;
  logic             mismatch;
  logic             stalled;
  logic [31:0]      edge_count;

  modport master (
    output clk_in, expect_period,
    input  tick_rise, tick_fall, period, high_time, period_valid,
           mismatch, stalled, edge_count
  );

  modport slave (
    input  clk_in, expect_period,
    output tick_rise, tick_fall, period, high_time, period_valid,
           mismatch, stalled, edge_count
  );
endinterface

// File: rtl/div_clk_monitor.sv
// Synchronises a divided clock into clk_100MHz, emits edge ticks, and measures
// period / high time against the programmed divide ratio with stall detection.
module div_clk_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 31,
  parameter int unsigned STALL_LIMIT = 1 << 20
) (
  input logic              clk_100MHz,
  input logic              rst_n,
  div_clk_monitor_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(STALL_LIMIT);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    MEASURE = 2'd1,
    RESYNC  = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_prev_q, s_prev_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       exp_q, exp_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic [CNT_W-1:0]       high_time_q, high_time_d;
  logic                   tick_rise_q, tick_rise_d;
  logic                   tick_fall_q, tick_fall_d;
  logic                   period_valid_q, period_valid_d;
  logic                   mismatch_q, mismatch_d;
  logic                   stalled_q, stalled_d;
  logic [31:0]            edge_count_q, edge_count_d;

  logic rise_c, fall_c, chg_c, stall_c;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ACQUIRE;
      sync_q         <= '0;
      s_prev_q       <= 1'b0;
      cnt_q          <= '0;
      exp_q          <= '0;
      period_q       <= '0;
      high_time_q    <= '0;
      tick_rise_q    <= 1'b0;
      tick_fall_q    <= 1'b0;
      period_valid_q <= 1'b0;
      mismatch_q     <= 1'b0;
      stalled_q      <= 1'b0;
      edge_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      s_prev_q       <= s_prev_d;
      cnt_q          <= cnt_d;
      exp_q          <= exp_d;
      period_q       <= period_d;
      high_time_q    <= high_time_d;
      tick_rise_q    <= tick_rise_d;
      tick_fall_q    <= tick_fall_d;
      period_valid_q <= period_valid_d;
      mismatch_q     <= mismatch_d;
      stalled_q      <= stalled_d;
      edge_count_q   <= edge_count_d;
    end
  end

  // Ratio reprogramming takes priority over stall, which takes priority over measuring.
  always_comb begin
    rise_c  = sync_q[SYNC_STAGES-1] & ~s_prev_q;
    fall_c  = ~sync_q[SYNC_STAGES-1] & s_prev_q;
    chg_c   = (bus.expect_period != exp_q);
    stall_c = (cnt_q == STALL_CNT) && !rise_c && !fall_c;

    sync_d         = {sync_q[SYNC_STAGES-2:0], bus.clk_in};
    s_prev_d       = sync_q[SYNC_STAGES-1];
    state_d        = state_q;
    exp_d          = exp_q;
    period_d       = period_q;
    high_time_d    = high_time_q;
    tick_rise_d    = rise_c;
    tick_fall_d    = fall_c;
    period_valid_d = 1'b0;
    mismatch_d     = mismatch_q;
    stalled_d      = stalled_q;
    edge_count_d   = edge_count_q;

    if (rise_c) begin
      cnt_d = CNT_W'(1);
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (rise_c) begin
      edge_count_d = edge_count_q + 32'd1;
      stalled_d    = 1'b0;
    end

    if (chg_c) begin
      state_d    = RESYNC;
      exp_d      = bus.expect_period;
      mismatch_d = 1'b0;
    end else if (stall_c) begin
      state_d   = ACQUIRE;
      stalled_d = 1'b1;
    end else begin
      case (state_q)
        ACQUIRE, RESYNC: begin
          if (rise_c) state_d = MEASURE;
        end
        MEASURE: begin
          if (rise_c) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            mismatch_d     = (bus.expect_period >= CNT_W'(2)) && (cnt_q != bus.expect_period);
          end else if (fall_c) begin
            high_time_d = cnt_q;
          end
        end
        default: state_d = ACQUIRE;
      endcase
    end
  end

  assign bus.tick_rise    = tick_rise_q;
  assign bus.tick_fall    = tick_fall_q;
  assign bus.period       = period_q;
  assign bus.high_time    = high_time_q;
  assign bus.period_valid = period_valid_q;
  assign bus.mismatch     = mismatch_q;
  assign bus.stalled      = stalled_q;
  assign bus.edge_count   = edge_count_q;

endmodule
